mul_pipe_vr: RTL

- Parametrised pipelined integer multiplier for the patch-building datapath. Successor to the fixed 18x20 -> 37-bit, 4-stage, free-running DSP multiplier.
- Adds configurable operand widths, per-operand signedness, configurable depth, a sideband tag, and a valid/ready handshake with backpressure and in-flight occupancy tracking.
- Sits between the edge/shadow-quilt arithmetic stages. Upstream and downstream may stall.

---
 rtl/mul_pipe_vr_if.sv | 33 +++
 rtl/mul_pipe_vr.sv | 107 ++++++++++
 2 files changed

// File: rtl/mul_pipe_vr_if.sv
// Handshake bundle for mul_pipe_vr: operand/tag input channel, product/tag
// output channel and the occupancy status seen by the control logic.
interface mul_pipe_vr_if #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 20,
  parameter int P_WIDTH   = 37,
  parameter int TAG_WIDTH = 8,
  parameter int NUM_STAGE = 4
);
  localparam int OCC_W = $clog2(NUM_STAGE + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   din0;
  logic [B_WIDTH-1:0]   din1;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_WIDTH-1:0]   dout;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [OCC_W-1:0]     occupancy;
  logic                 busy;

  modport master (
    output in_valid, din0, din1, in_tag, out_ready,
    input  in_ready, out_valid, dout, out_tag, occupancy, busy
  );

  modport slave (
    input  in_valid, din0, din1, in_tag, out_ready,
    output in_ready, out_valid, dout, out_tag, occupancy, busy
  );
endinterface

// File: rtl/mul_pipe_vr.sv
// Pipelined integer multiplier with configurable widths, signedness and depth,
// carrying a sideband tag and honouring valid/ready backpressure end to end.
module mul_pipe_vr #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 20,
  parameter int P_WIDTH   = 37,
  parameter int NUM_STAGE = 4,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0,
  parameter int TAG_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  mul_pipe_vr_if.slave  bus
);
  localparam int FULL_W = A_WIDTH + B_WIDTH;
  localparam int EXT_W  = (P_WIDTH > FULL_W) ? P_WIDTH : FULL_W;
  localparam int OCC_W  = $clog2(NUM_STAGE + 1);

  logic                 adv;
  logic                 accept;
  logic                 out_hs;

  logic                 s1_valid;
  logic [A_WIDTH-1:0]   s1_a;
  logic [B_WIDTH-1:0]   s1_b;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic [EXT_W-1:0]     a_ext;
  logic [EXT_W-1:0]     b_ext;
  logic [P_WIDTH-1:0]   prod_p;

  logic                 valid_q [2:NUM_STAGE];
  logic [P_WIDTH-1:0]   data_q  [2:NUM_STAGE];
  logic [TAG_WIDTH-1:0] tag_q   [2:NUM_STAGE];

  logic [OCC_W-1:0]     occ_q;

  // The whole pipe moves as one unit, so a single advance term gates every stage.
  assign adv    = !valid_q[NUM_STAGE] || bus.out_ready;
  assign accept = bus.in_valid && adv;
  assign out_hs = valid_q[NUM_STAGE] && bus.out_ready;

  // Extending each operand to the wider of the full-product and output widths
  // and keeping the low P_WIDTH bits gives both the wrap and the extension cases.
  if (A_SIGNED != 0) begin : g_a_signed
    assign a_ext = EXT_W'($signed(s1_a));
  end else begin : g_a_unsigned
    assign a_ext = EXT_W'(s1_a);
  end

  if (B_SIGNED != 0) begin : g_b_signed
    assign b_ext = EXT_W'($signed(s1_b));
  end else begin : g_b_unsigned
    assign b_ext = EXT_W'(s1_b);
  end

  assign prod_p = P_WIDTH'(a_ext * b_ext);

  // Stage 1 captures operands, stage 2 captures the product, the rest delay it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
      for (int i = 2; i <= NUM_STAGE; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        tag_q[i]   <= '0;
      end
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.din0;
        s1_b   <= bus.din1;
        s1_tag <= bus.in_tag;
      end
      valid_q[2] <= s1_valid;
      data_q[2]  <= prod_p;
      tag_q[2]   <= s1_tag;
      for (int i = 3; i <= NUM_STAGE; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  // Simultaneous accept and output handshake leave the in-flight count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else if (accept && !out_hs) begin
      occ_q <= occ_q + 1'b1;
    end else if (out_hs && !accept) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[NUM_STAGE];
  assign bus.dout      = data_q[NUM_STAGE];
  assign bus.out_tag   = tag_q[NUM_STAGE];
  assign bus.occupancy = occ_q;
  assign bus.busy      = (occ_q != '0);
endmodule
